proximity_alarm: RTL and testbench
==================================

// Module: proximity_alarm
// PURPOSE
//  Consumes the HC-SR04 measurement stage outputs (trig, relative_distance) and forms a
//  parking-sensor alarm. A 2**log2_window moving average smooths the readings; a hysteresis
//  FSM decides NEAR/FAR. While NEAR, a tone generator drives a buzzer in beeps whose gaps
//  shrink with distance. Sits between the distance sensor and board LED/buzzer pins.
// PARAMETERS
//  clk_frequency            50000000  clk Hz
//  relative_distance_width  8         width of relative_distance / avg_distance
//  log2_window              2         moving-average depth N = 2**log2_window samples
//  near_threshold           32        FAR->NEAR when avg_distance <  near_threshold
//  far_threshold            40        NEAR->FAR when avg_distance >= far_threshold (> near_threshold)
//  beep_in_milliseconds     50        tone-on time per beep
//  gap_ms_per_unit          4         silent gap per avg_distance LSB, in ms
//  tone_frequency           2000      buzzer square-wave Hz
// PORTS
//  clk                input   1     system clock
//  reset              input   1     asynchronous, active-high
//  trig               input   1     sensor trigger; its rising edge marks "previous measurement final"
//  relative_distance  input   RDW   latest distance from sensor (RDW = relative_distance_width)
//  avg_distance       output  RDW   moving average, registered
//  avg_valid          output  1     1 once N samples have been accumulated since reset
//  near               output  1     1 while FSM in NEAR
//  buzzer             output  1     square-wave tone / 0
// BEHAVIOUR
//  Reset (async, any time): avg_distance=0, avg_valid=0, near=0, buzzer=0, buffer/sum/fill=0,
//   FSM=FAR, all timers 0. Mid-operation reset discards partial window; refill needs N samples.
//  Sample strobe: prev_trig register; strobe = trig & ~prev_trig (one cycle per trig rise).
//  Cycle S (strobe high): write relative_distance into circular buffer slot wr_ptr, wr_ptr++ (wraps
//   mod N), sum <= sum + new - oldest(slot being overwritten; 0 while filling), fill++ saturating at N.
//  Cycle S+1: avg_distance <= sum >> log2_window; avg_valid <= (fill == N). Latency: 2 clk strobe->avg.
//  sum width RDW+log2_window: never overflows. Before avg_valid, avg_distance stays 0.
//  Back-to-back strobes (min spacing 2 clk by edge detect) are each accepted; no sample is dropped.
//  Alarm FSM, evaluated every cycle on registered avg_distance:
//   FAR : avg_valid && avg_distance < near_threshold -> NEAR_BEEP (timers cleared, tone phase 0)
//   NEAR_BEEP: buzzer = tone; after beep_cycles clk -> NEAR_GAP, latching
//     gap_len = avg_distance * gap_cycles_per_unit; if gap_len==0 stay in NEAR_BEEP (continuous tone)
//   NEAR_GAP : buzzer = 0; after gap_len clk -> NEAR_BEEP. avg changes mid-gap do not alter gap_len.
//   Any NEAR_* with avg_distance >= far_threshold -> FAR; buzzer 0 and timers cleared next cycle.
//  Between thresholds: state held (hysteresis). near = (state != FAR), registered.
//  Derived: beep_cycles = beep_in_milliseconds*(clk_frequency/1000);
//   gap_cycles_per_unit = gap_ms_per_unit*(clk_frequency/1000);
//   tone_half = clk_frequency/(2*tone_frequency); tone toggles every tone_half clk, starts low.
//  Gap counter width: $clog2((2**RDW-1)*gap_cycles_per_unit+1).
// STRUCTURE
//  Shared package ultrasonic_pkg: speed-of-sound/cm-per-unit constants, cycles_per_ms helper,
//   FSM state encoding (FAR, NEAR_BEEP, NEAR_GAP).
//  One sub-module: tone_generator (clk, reset, enable, half_period param) -> square wave;
//   held at 0 and phase cleared when enable=0. Averager and FSM stay in this module.
// TESTING  (sim params: clk_frequency=1000000, log2_window=2, beep=2 ms, gap_ms_per_unit=1,
//           tone_frequency=10000 -> tone_half=50, beep_cycles=2000, gap 1000 clk/unit)
//  1 reset, 3 trig pulses with distance 20 -> avg_valid=0, avg_distance=0, near=0, buzzer=0.
//  2 4th pulse (dist 20) -> avg_valid=1, avg_distance=20 exactly 2 clk after trig rise; near=1 next clk.
//  3 window slide: feed 100,100,100,100 then 0 -> avg 100 then 75; FSM: 75>=40 -> FAR, buzzer 0.
//  4 avg=10 in NEAR: buzzer toggles every 50 clk for 2000 clk, then 0 for 10000 clk, repeat.
//  5 hysteresis: avg 30 -> NEAR; 35 stays NEAR; 39 stays NEAR; 40 -> FAR; 35 stays FAR.
//  6 avg=0 -> continuous tone; assert reset mid-beep -> all outputs 0 same cycle, refill needs 4 pulses.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared constants, helper and alarm FSM encoding for the ultrasonic sensor blocks.
//   SPEED_OF_SOUND_M_PER_S : speed of sound used by the measurement stage
//   US_PER_CM_ROUND_TRIP   : echo time per centimetre of target distance
//   cycles_per_ms()        : converts a millisecond count into clock cycles
//   alarm_state_t          : proximity alarm FSM states
package ultrasonic_pkg;

    localparam int unsigned SPEED_OF_SOUND_M_PER_S = 343;
    localparam int unsigned US_PER_CM_ROUND_TRIP   = 58;

    typedef enum logic [1:0] {
        FAR       = 2'd0,
        NEAR_BEEP = 2'd1,
        NEAR_GAP  = 2'd2
    } alarm_state_t;

    function automatic int unsigned cycles_per_ms(input int unsigned clk_hz,
                                                  input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/tone_generator.sv
// Square-wave tone source for the buzzer.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : run the tone; when low the output is 0 and the phase restarts
//   tone       : registered square wave, toggles every half_period clocks, starts low
module tone_generator
    import ultrasonic_pkg::*;
#(
    parameter int unsigned half_period = 25000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tone
);

    localparam int unsigned CW = (half_period > 1) ? $clog2(half_period) : 1;
    localparam logic [CW-1:0] LAST = CW'(half_period - 1);

    logic [CW-1:0] count;

    // Half-period counter; disabling clears the phase so each beep starts low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tone  <= 1'b0;
        end else if (!enable) begin
            count <= '0;
            tone  <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            tone  <= ~tone;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/proximity_alarm.sv
// Parking-sensor alarm: moving average of sensor distances, hysteresis NEAR/FAR decision,
// and a beeping buzzer whose silent gaps scale with the averaged distance.
//   clk, reset        : clock, asynchronous active-high reset
//   trig              : sensor trigger; each rising edge takes one relative_distance sample
//   relative_distance : latest distance reading
//   avg_distance      : registered moving average (0 until the window is full)
//   avg_valid         : window holds 2**log2_window samples since reset
//   near              : alarm is in a NEAR state
//   buzzer            : tone during beeps, 0 otherwise
module proximity_alarm
    import ultrasonic_pkg::*;
#(
    parameter int unsigned clk_frequency           = 50000000,
    parameter int unsigned relative_distance_width = 8,
    parameter int unsigned log2_window             = 2,
    parameter int unsigned near_threshold          = 32,
    parameter int unsigned far_threshold           = 40,
    parameter int unsigned beep_in_milliseconds    = 50,
    parameter int unsigned gap_ms_per_unit         = 4,
    parameter int unsigned tone_frequency          = 2000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               trig,
    input  logic [relative_distance_width-1:0] relative_distance,
    output logic [relative_distance_width-1:0] avg_distance,
    output logic                               avg_valid,
    output logic                               near,
    output logic                               buzzer
);

    localparam int unsigned RDW         = relative_distance_width;
    localparam int unsigned L           = log2_window;
    localparam int unsigned N           = 2 ** L;
    localparam int unsigned SW          = RDW + L;
    localparam int unsigned FW          = L + 1;
    localparam int unsigned BEEP_CYCLES = cycles_per_ms(clk_frequency, beep_in_milliseconds);
    localparam int unsigned GAP_CPU     = cycles_per_ms(clk_frequency, gap_ms_per_unit);
    localparam int unsigned TONE_HALF   = clk_frequency / (2 * tone_frequency);
    localparam int unsigned BW          = $clog2(BEEP_CYCLES + 1);
    localparam int unsigned GW          = $clog2((2 ** RDW - 1) * GAP_CPU + 1);

    localparam logic [FW-1:0]  FILL_FULL = FW'(N);
    localparam logic [RDW-1:0] NEAR_TH   = RDW'(near_threshold);
    localparam logic [RDW-1:0] FAR_TH    = RDW'(far_threshold);
    localparam logic [BW-1:0]  BEEP_LAST = BW'(BEEP_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_CPU_W = GW'(GAP_CPU);

    // ---------------- moving average ----------------
    logic           prev_trig;
    logic           strobe;
    logic [RDW-1:0] window [N];
    logic [L-1:0]   wr_ptr;
    logic [SW-1:0]  sum;
    logic [FW-1:0]  fill;
    logic [RDW-1:0] oldest;

    assign strobe = trig & ~prev_trig;
    // Slots not yet written contribute nothing while the window fills.
    assign oldest = (fill == FILL_FULL) ? window[wr_ptr] : '0;

    // Running sum over a circular buffer; the average follows one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_trig    <= 1'b0;
            wr_ptr       <= '0;
            sum          <= '0;
            fill         <= '0;
            avg_distance <= '0;
            avg_valid    <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                window[i] <= '0;
            end
        end else begin
            prev_trig <= trig;
            if (strobe) begin
                window[wr_ptr] <= relative_distance;
                wr_ptr         <= wr_ptr + L'(1);
                sum            <= sum + SW'(relative_distance) - SW'(oldest);
                if (fill != FILL_FULL) begin
                    fill <= fill + FW'(1);
                end
            end
            avg_valid    <= (fill == FILL_FULL);
            avg_distance <= (fill == FILL_FULL) ? RDW'(sum >> L) : '0;
        end
    end

    // ---------------- alarm FSM ----------------
    alarm_state_t  state;
    logic [BW-1:0] beep_cnt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_len;
    logic [GW-1:0] next_gap;
    logic          tone_en;

    assign next_gap = GW'(avg_distance) * GAP_CPU_W;
    assign tone_en  = (state == NEAR_BEEP);

    // Hysteresis decision plus beep/gap sequencing; far exit has priority over timers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FAR;
            near     <= 1'b0;
            beep_cnt <= '0;
            gap_cnt  <= '0;
            gap_len  <= '0;
        end else if (state != FAR && avg_distance >= FAR_TH) begin
            state    <= FAR;
            near     <= 1'b0;
            beep_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                FAR: begin
                    if (avg_valid && avg_distance < NEAR_TH) begin
                        state    <= NEAR_BEEP;
                        near     <= 1'b1;
                        beep_cnt <= '0;
                        gap_cnt  <= '0;
                    end
                end
                NEAR_BEEP: begin
                    if (beep_cnt == BEEP_LAST) begin
                        beep_cnt <= '0;
                        // Zero-length gap means the tone simply continues.
                        if (next_gap != '0) begin
                            state   <= NEAR_GAP;
                            gap_len <= next_gap;
                            gap_cnt <= '0;
                        end
                    end else begin
                        beep_cnt <= beep_cnt + BW'(1);
                    end
                end
                NEAR_GAP: begin
                    if (gap_cnt == gap_len - GW'(1)) begin
                        state    <= NEAR_BEEP;
                        gap_cnt  <= '0;
                        beep_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= FAR;
                    near  <= 1'b0;
                end
            endcase
        end
    end

    tone_generator #(
        .half_period (TONE_HALF)
    ) u_tone (
        .clk    (clk),
        .reset  (reset),
        .enable (tone_en),
        .tone   (buzzer)
    );

endmodule

// File: tb/tb_proximity_alarm.sv
// Self-checking bench for proximity_alarm: directed scenarios with literal expectations
// plus randomized sampling compared each cycle against a behavioural model.
module tb_proximity_alarm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       trig = 1'b0;
    logic [7:0] relative_distance = 8'd0;
    logic [7:0] avg_distance;
    logic       avg_valid;
    logic       near;
    logic       buzzer;

    int n_checks = 0;
    int n_fail   = 0;

    proximity_alarm #(
        .clk_frequency           (1000000),
        .relative_distance_width (8),
        .log2_window             (2),
        .near_threshold          (32),
        .far_threshold           (40),
        .beep_in_milliseconds    (2),
        .gap_ms_per_unit         (1),
        .tone_frequency          (10000)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .trig              (trig),
        .relative_distance (relative_distance),
        .avg_distance      (avg_distance),
        .avg_valid         (avg_valid),
        .near              (near),
        .buzzer            (buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Average = floor(mean of the last 4 accepted samples), visible 2 clocks after the trig
    // rise is seen. Alarm tracked as NEAR/FAR plus "time into current beep or gap".
    int win[$];
    bit m_prev_trig;
    bit avg_due;
    int e_avg, e_valid, e_near, e_buz;
    bit in_beep;
    int t, gap;

    always @(posedge clk or posedge reset) begin
        int old_avg;
        int old_valid;
        int s;
        if (reset) begin
            win.delete();
            m_prev_trig = 0; avg_due = 0;
            e_avg = 0; e_valid = 0; e_near = 0; e_buz = 0;
            in_beep = 0; t = 0; gap = 0;
        end else begin
            old_avg = e_avg;
            old_valid = e_valid;
            e_buz = 0;
            if (e_near == 0) begin
                if (old_valid != 0 && old_avg < 32) begin
                    e_near = 1; in_beep = 1; t = 0;
                end
            end else if (old_avg >= 40) begin
                // tone still ran on this edge: t+1 enabled clocks since the beep began
                if (in_beep) e_buz = ((t + 1) / 50) % 2;
                e_near = 0; in_beep = 0; t = 0;
            end else begin
                t++;
                if (in_beep && t == 2000) begin
                    t = 0;
                    if (old_avg != 0) begin
                        in_beep = 0; gap = old_avg * 1000;
                    end
                end else if (!in_beep && t == gap) begin
                    in_beep = 1; t = 0;
                end
                if (in_beep) e_buz = (t / 50) % 2;
            end
            if (avg_due) begin
                s = 0;
                foreach (win[i]) s += win[i];
                e_valid = (win.size() == 4) ? 1 : 0;
                e_avg = (e_valid != 0) ? s / 4 : 0;
                avg_due = 0;
            end
            if (trig && !m_prev_trig) begin
                win.push_back(int'(relative_distance));
                if (win.size() > 4) void'(win.pop_front());
                avg_due = 1;
            end
            m_prev_trig = trig;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("avg_distance", int'(avg_distance), e_avg);
            check("avg_valid", int'(avg_valid), e_valid);
            check("near", int'(near), e_near);
            check("buzzer", int'(buzzer), e_buz);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle trig pulse; returns just after the edge where the new average is visible.
    task automatic pulse(input int d);
        relative_distance = 8'(d);
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        step(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        int target;
        int d;
        step(3);
        check("reset_avg", int'(avg_distance), 0);
        check("reset_valid", int'(avg_valid), 0);
        check("reset_near", int'(near), 0);
        check("reset_buzzer", int'(buzzer), 0);
        reset = 1'b0;

        // partial window
        repeat (3) pulse(20);
        check("fill3_valid", int'(avg_valid), 0);
        check("fill3_avg", int'(avg_distance), 0);
        check("fill3_near", int'(near), 0);
        check("fill3_buzzer", int'(buzzer), 0);

        // fourth sample completes the window; near follows one clock later
        pulse(20);
        check("fill4_avg", int'(avg_distance), 20);
        check("fill4_valid", int'(avg_valid), 1);
        check("fill4_near_lag", int'(near), 0);
        step(1);
        check("fill4_near", int'(near), 1);

        // window slide and far exit
        repeat (4) pulse(100);
        check("slide_avg100", int'(avg_distance), 100);
        pulse(0);
        check("slide_avg75", int'(avg_distance), 75);
        step(1);
        check("slide_near", int'(near), 0);
        check("slide_buzzer", int'(buzzer), 0);

        // avg 10: 2000-clock beep at 50-clock half period, then 10000-clock gap
        do_reset();
        repeat (4) pulse(10);
        step(1);
        check("beep_near", int'(near), 1);
        check("beep_k0", int'(buzzer), 0);
        step(49);   check("beep_k49", int'(buzzer), 0);
        step(1);    check("beep_k50", int'(buzzer), 1);
        step(49);   check("beep_k99", int'(buzzer), 1);
        step(1);    check("beep_k100", int'(buzzer), 0);
        step(1899); check("beep_k1999", int'(buzzer), 1);
        step(1);    check("gap_k2000", int'(buzzer), 0);
        step(9999); check("gap_k11999", int'(buzzer), 0);
        step(1);    check("beep2_k12000", int'(buzzer), 0);
        step(50);   check("beep2_k12050", int'(buzzer), 1);

        // hysteresis
        do_reset();
        repeat (4) pulse(30);
        step(1);
        check("hyst30_near", int'(near), 1);
        repeat (4) pulse(35);
        check("hyst35_avg", int'(avg_distance), 35);
        check("hyst35_near", int'(near), 1);
        repeat (4) pulse(39);
        step(1);
        check("hyst39_near", int'(near), 1);
        repeat (4) pulse(40);
        check("hyst40_avg", int'(avg_distance), 40);
        step(1);
        check("hyst40_near", int'(near), 0);
        repeat (4) pulse(35);
        step(1);
        check("hyst35_far_avg", int'(avg_distance), 35);
        check("hyst35_far_near", int'(near), 0);

        // avg 0: continuous tone, then asynchronous reset mid-beep
        do_reset();
        repeat (4) pulse(0);
        step(1);
        check("cont_near", int'(near), 1);
        step(2050);
        check("cont_k2050", int'(buzzer), 1);
        reset = 1'b1;
        #1;
        check("arst_avg", int'(avg_distance), 0);
        check("arst_valid", int'(avg_valid), 0);
        check("arst_near", int'(near), 0);
        check("arst_buzzer", int'(buzzer), 0);
        step(1);
        reset = 1'b0;
        repeat (3) pulse(40);
        check("refill3_valid", int'(avg_valid), 0);
        pulse(40);
        check("refill4_valid", int'(avg_valid), 1);
        check("refill4_avg", int'(avg_distance), 40);

        // randomized sampling around the thresholds, one asynchronous reset mid-run
        do_reset();
        target = 30;
        for (int i = 0; i < 250; i++) begin
            if (i % 8 == 0) target = int'($urandom_range(0, 60));
            d = target + int'($urandom_range(0, 6)) - 3;
            if (d < 0) d = 0;
            if ($urandom_range(0, 29) == 0) d = int'($urandom_range(0, 255));
            pulse(d);
            step(int'($urandom_range(0, 40)));
            if (i == 125) begin
                #(int'($urandom_range(1, 7)));
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end
        end
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
